// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Bridges the core's execute stage to a word-addressed, asynchronously read
// memory. Byte-addressed loads/stores (byte, half, word) become single-word
// memory accesses. Loads pick the addressed lane and sign/zero extend it.
// Sub-word stores read the word, merge the new lane(s) and write it back.
//
// Ports
//   Clock, ResetN                  clock (rising edge), async active-low reset
//   ReqValid/ReqReady              request handshake (ready only in IDLE)
//   ReqWrite, ReqSize, ReqUnsigned request kind: store/load, 00/01/10 size
//   ReqAddr, ReqWData              byte address, right-aligned store data
//   RespValid/RespData/RespError   one-cycle completion pulse with result
//   MemStatus, MemAddress, MemI    memory write enable, word index, write data
//   MemQ                           memory read data (combinational from index)
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int WordSize        = 32,
    parameter int WordsNumberLog2 = 8,
    parameter int AddrWidth       = 32
) (
    input  logic                       Clock,
    input  logic                       ResetN,
    input  logic                       ReqValid,
    output logic                       ReqReady,
    input  logic                       ReqWrite,
    input  logic [1:0]                 ReqSize,
    input  logic                       ReqUnsigned,
    input  logic [AddrWidth-1:0]       ReqAddr,
    input  logic [WordSize-1:0]        ReqWData,
    output logic                       RespValid,
    output logic [WordSize-1:0]        RespData,
    output logic                       RespError,
    output logic                       MemStatus,
    output logic [WordsNumberLog2-1:0] MemAddress,
    output logic [WordSize-1:0]        MemI,
    input  logic [WordSize-1:0]        MemQ
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Extracts the addressed lane (little-endian) and extends it to a word.
    function automatic logic [WordSize-1:0] load_extend(
        input logic [WordSize-1:0] word,
        input logic [1:0]          size,
        input logic [1:0]          lane,
        input logic                uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Replaces the addressed byte or half of the old word with the store data.
    function automatic logic [WordSize-1:0] store_merge(
        input logic [WordSize-1:0] word,
        input logic [15:0]         data,
        input logic [1:0]          size,
        input logic [1:0]          lane
    );
        store_merge = word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    store_merge[7:0]   = data[7:0];
                    2'd1:    store_merge[15:8]  = data[7:0];
                    2'd2:    store_merge[23:16] = data[7:0];
                    2'd3:    store_merge[31:24] = data[7:0];
                    default: store_merge = word;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    store_merge[31:16] = data;
                end else begin
                    store_merge[15:0] = data;
                end
            end
            default: store_merge = word;
        endcase
    endfunction

    logic [1:0]                 state_r;
    logic                       ready_r;
    logic                       write_r;
    logic [1:0]                 size_r;
    logic                       unsigned_r;
    logic [1:0]                 lane_r;
    logic [15:0]                wdata_r;
    logic                       resp_valid_r;
    logic                       resp_error_r;
    logic [WordSize-1:0]        resp_data_r;
    logic                       mem_status_r;
    logic [WordsNumberLog2-1:0] mem_address_r;
    logic [WordSize-1:0]        mem_i_r;

    logic size_err_s;
    logic range_err_s;
    logic err_s;
    logic accept_s;

    // Size / alignment legality of the incoming request.
    always_comb begin
        size_err_s = 1'b0;
        if (ReqSize == 2'b11) begin
            size_err_s = 1'b1;
        end else if (ReqSize == SZ_HALF) begin
            size_err_s = ReqAddr[0];
        end else if (ReqSize == SZ_WORD) begin
            size_err_s = |ReqAddr[1:0];
        end else begin
            size_err_s = 1'b0;
        end
    end

    // Any address bit above the memory's word range makes the request illegal.
    assign range_err_s = |ReqAddr[AddrWidth-1:WordsNumberLog2+2];
    assign err_s       = size_err_s | range_err_s;
    assign accept_s    = ReqValid & ready_r;

    // Request capture, FSM sequencing and all registered outputs.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_r       <= ST_IDLE;
            ready_r       <= 1'b1;
            write_r       <= 1'b0;
            size_r        <= 2'd0;
            unsigned_r    <= 1'b0;
            lane_r        <= 2'd0;
            wdata_r       <= 16'd0;
            resp_valid_r  <= 1'b0;
            resp_error_r  <= 1'b0;
            resp_data_r   <= {WordSize{1'b0}};
            mem_status_r  <= 1'b0;
            mem_address_r <= {WordsNumberLog2{1'b0}};
            mem_i_r       <= {WordSize{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        write_r       <= ReqWrite;
                        size_r        <= ReqSize;
                        unsigned_r    <= ReqUnsigned;
                        lane_r        <= ReqAddr[1:0];
                        wdata_r       <= ReqWData[15:0];
                        mem_address_r <= ReqAddr[WordsNumberLog2+1:2];
                        resp_data_r   <= {WordSize{1'b0}};
                        ready_r       <= 1'b0;
                        if (err_s) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_error_r <= 1'b1;
                        end else if (ReqWrite && (ReqSize == SZ_WORD)) begin
                            // Whole-word store needs no read: write next cycle.
                            state_r      <= ST_WRITE;
                            mem_i_r      <= ReqWData;
                            mem_status_r <= 1'b1;
                        end else begin
                            state_r <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    // MemQ already reflects mem_address_r (async read).
                    if (write_r) begin
                        mem_i_r      <= store_merge(MemQ, wdata_r, size_r, lane_r);
                        mem_status_r <= 1'b1;
                        state_r      <= ST_WRITE;
                    end else begin
                        resp_data_r  <= load_extend(MemQ, size_r, lane_r, unsigned_r);
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    mem_status_r <= 1'b0;
                    resp_valid_r <= 1'b1;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_r <= 1'b0;
                    resp_error_r <= 1'b0;
                    resp_data_r  <= {WordSize{1'b0}};
                    ready_r      <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    resp_error_r <= 1'b0;
                    mem_status_r <= 1'b0;
                    ready_r      <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign ReqReady   = ready_r;
    assign RespValid  = resp_valid_r;
    assign RespError  = resp_error_r;
    assign RespData   = resp_data_r;
    assign MemStatus  = mem_status_r;
    assign MemAddress = mem_address_r;
    assign MemI       = mem_i_r;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        Clock;
    logic        ResetN;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespError;
    logic        MemStatus;
    logic [7:0]  MemAddress;
    logic [31:0] MemI;
    logic [31:0] MemQ;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    logic        mem_clear;

    load_store_unit dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqWrite   (ReqWrite),
        .ReqSize    (ReqSize),
        .ReqUnsigned(ReqUnsigned),
        .ReqAddr    (ReqAddr),
        .ReqWData   (ReqWData),
        .RespValid  (RespValid),
        .RespData   (RespData),
        .RespError  (RespError),
        .MemStatus  (MemStatus),
        .MemAddress (MemAddress),
        .MemI       (MemI),
        .MemQ       (MemQ)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory model: asynchronous read, write on rising edge when MemStatus=1.
    assign MemQ = mem[MemAddress];
    always @(posedge Clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (MemStatus) begin
            mem[MemAddress] <= MemI;
        end
    end

    // Drives one request, then watches cycles 1..10 after the accept edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rdata,
                         output logic rerr, output int nwr,
                         output logic [7:0] waddr, output logic tail);
        @(negedge Clock);
        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqUnsigned = u;
        ReqAddr = a; ReqWData = d;
        @(negedge Clock);
        // Scramble fields after accept: the unit must use its captured copy.
        ReqValid = 1'b0; ReqWrite = ~w; ReqSize = 2'b11; ReqUnsigned = ~u;
        ReqAddr = 32'hFFFF_FFFF; ReqWData = 32'h5A5A_5A5A;
        lat = 0; nwr = 0; rdata = 32'd0; rerr = 1'b0; waddr = 8'd0; tail = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (MemStatus) begin
                nwr++;
                waddr = MemAddress;
            end
            if (RespValid) begin
                lat = k; rdata = RespData; rerr = RespError;
                break;
            end
            @(negedge Clock);
        end
        @(negedge Clock);
        tail = RespValid;
        ReqWrite = 1'b0; ReqSize = 2'b10; ReqUnsigned = 1'b0;
        ReqAddr = 32'd0; ReqWData = 32'd0;
    endtask

    task automatic test_reset();
        ResetN = 1'b0; mem_clear = 1'b1;
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqUnsigned = 1'b0;
        ReqAddr = 32'h10; ReqWData = 32'h1234_5678;
        repeat (3) @(negedge Clock);
        checks++;
        if (ReqReady !== 1'b1 || RespValid !== 1'b0 || RespError !== 1'b0 ||
            MemStatus !== 1'b0 || MemAddress !== 8'd0 || MemI !== 32'd0 ||
            RespData !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b rv=%b re=%b ms=%b ma=%h mi=%h rd=%h, want 1 0 0 0 00 0 0",
                     ReqReady, RespValid, RespError, MemStatus, MemAddress, MemI, RespData);
        end
        ReqValid = 1'b0; mem_clear = 1'b0;
        ResetN = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if (ReqReady !== 1'b1 || RespValid !== 1'b0 || MemStatus !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b rv=%b ms=%b, want 1 0 0",
                     ReqReady, RespValid, MemStatus);
        end
    endtask

    task automatic test_word();
        int lat, nwr; logic [31:0] rd; logic re, tail; logic [7:0] wa;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, re, nwr, wa, tail);
        checks++;
        if (lat != 2 || nwr != 1 || wa !== 8'd4 || re !== 1'b0 || rd !== 32'd0 || tail !== 1'b0) begin
            errors++;
            $display("FAIL sw_0x10: got lat=%0d nwr=%0d waddr=%0d err=%b data=%h tail=%b, want 2 1 4 0 0 0",
                     lat, nwr, wa, re, rd, tail);
        end
        checks++;
        if (mem[4] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_mem: got %h want deadbeef", mem[4]);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, re, nwr, wa, tail);
        checks++;
        if (lat != 2 || nwr != 0 || re !== 1'b0 || rd !== 32'hDEAD_BEEF || tail !== 1'b0) begin
            errors++;
            $display("FAIL lw_0x10: got lat=%0d nwr=%0d err=%b data=%h tail=%b, want 2 0 0 deadbeef 0",
                     lat, nwr, re, rd, tail);
        end
    endtask

    task automatic test_subword();
        int lat, nwr; logic [31:0] rd; logic re, tail; logic [7:0] wa;
        // {write, size, unsigned, addr, wdata, expected latency, expected data}
        logic        vw [12];
        logic [1:0]  vs [12];
        logic        vu [12];
        logic [31:0] va [12];
        logic [31:0] vd [12];
        int          vl [12];
        logic [31:0] ve [12];
        vw = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vs = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00};
        vu = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        va = '{32'h13, 32'h10, 32'h13, 32'h13, 32'h10, 32'h10, 32'h12, 32'h12, 32'h10, 32'h10, 32'h20, 32'h21};
        vd = '{32'hA5, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_1234, 32'h0, 32'h0, 32'h0, 32'h0,
               32'h1122_3344, 32'h0000_01FF};
        vl = '{3, 2, 2, 2, 2, 3, 2, 2, 2, 2, 2, 3};
        ve = '{32'h0, 32'hA5AD_BEEF, 32'hFFFF_FFA5, 32'h0000_00A5, 32'h0, 32'h0, 32'hFFFF_DEAD,
               32'h0000_DEAD, 32'h0000_0034, 32'h0000_1234, 32'h0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            issue(vw[i], vs[i], vu[i], va[i], vd[i], lat, rd, re, nwr, wa, tail);
            checks++;
            if (lat != vl[i] || nwr != int'(vw[i]) || re !== 1'b0 || rd !== ve[i] || tail !== 1'b0) begin
                errors++;
                $display("FAIL subword_%0d: got lat=%0d nwr=%0d err=%b data=%h tail=%b, want %0d %0d 0 %h 0",
                         i, lat, nwr, re, rd, tail, vl[i], vw[i], ve[i]);
            end
        end
        checks++;
        if (mem[4] !== 32'hDEAD_1234 || mem[8] !== 32'h1122_FF44) begin
            errors++;
            $display("FAIL subword_mem: got m4=%h m8=%h want dead1234 1122ff44", mem[4], mem[8]);
        end
    endtask

    task automatic test_errors();
        int lat, nwr; logic [31:0] rd; logic re, tail; logic [7:0] wa;
        logic        vw [5];
        logic [1:0]  vs [5];
        logic [31:0] va [5];
        vw = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vs = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
        va = '{32'h11, 32'h13, 32'h10, 32'h400, 32'h400};
        for (int i = 0; i < 5; i++) begin
            issue(vw[i], vs[i], 1'b0, va[i], 32'h0000_FFFF, lat, rd, re, nwr, wa, tail);
            checks++;
            if (lat != 1 || nwr != 0 || re !== 1'b1 || rd !== 32'd0 || tail !== 1'b0) begin
                errors++;
                $display("FAIL error_%0d: got lat=%0d nwr=%0d err=%b data=%h tail=%b, want 1 0 1 0 0",
                         i, lat, nwr, re, rd, tail);
            end
        end
        checks++;
        if (mem[4] !== 32'hDEAD_1234 || mem[0] !== 32'd0) begin
            errors++;
            $display("FAIL error_mem: got m4=%h m0=%h want dead1234 0", mem[4], mem[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_w, seen_v;
        @(negedge Clock);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b00; ReqUnsigned = 1'b0;
        ReqAddr = 32'h20; ReqWData = 32'h77;
        @(negedge Clock);
        ReqValid = 1'b0;
        ResetN = 1'b0;
        #1;
        checks++;
        if (MemStatus !== 1'b0 || ReqReady !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async: got ms=%b rdy=%b, want 0 1", MemStatus, ReqReady);
        end
        seen_w = 1'b0; seen_v = 1'b0;
        repeat (2) begin
            @(negedge Clock);
            seen_w = seen_w | MemStatus;
        end
        ResetN = 1'b1;
        repeat (4) begin
            @(negedge Clock);
            seen_w = seen_w | MemStatus;
            seen_v = seen_v | RespValid;
        end
        checks++;
        if (seen_w !== 1'b0 || seen_v !== 1'b0 || ReqReady !== 1'b1 || mem[8] !== 32'h1122_FF44) begin
            errors++;
            $display("FAIL midreset_after: got wr=%b rv=%b rdy=%b m8=%h, want 0 0 1 1122ff44",
                     seen_w, seen_v, ReqReady, mem[8]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [31:0] exp_d [4];
        logic [31:0] rd    [4];
        int          acc   [4];
        int          rt    [4];
        int          sent, nresp;
        addrs = '{32'h10, 32'h20, 32'h14, 32'h10};
        exp_d = '{32'hDEAD_1234, 32'h1122_FF44, 32'h0, 32'hDEAD_1234};
        sent = 0; nresp = 0;
        for (int i = 0; i < 4; i++) begin
            acc[i] = -100; rt[i] = -100; rd[i] = 32'hX;
        end
        for (int t = 0; t < 24; t++) begin
            @(negedge Clock);
            if (RespValid) begin
                if (nresp < 4) begin
                    rd[nresp] = RespData;
                    rt[nresp] = t;
                end
                nresp++;
            end
            if (sent < 4) begin
                ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b10; ReqUnsigned = 1'b0;
                ReqAddr = addrs[sent];
                if (ReqReady) begin
                    acc[sent] = t;
                    sent++;
                end
            end else begin
                ReqValid = 1'b0;
            end
        end
        checks++;
        if (nresp != 4 || sent != 4) begin
            errors++;
            $display("FAIL b2b_count: got resp=%0d sent=%0d, want 4 4", nresp, sent);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc[i] != acc[0] + 3 * i || rt[i] != acc[i] + 2 || rd[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL b2b_%0d: got acc=%0d resp=%0d data=%h, want acc=%0d resp=%0d data=%h",
                         i, acc[i], rt[i], rd[i], acc[0] + 3 * i, acc[i] + 2, exp_d[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
